ysyx_25020037_axi_rd_master: RTL and testbench
==============================================

Name: ysyx_25020037_axi_rd_master

Overview:
AXI4 read-channel initiator. Turns single-request read commands from a core-side client (IFU/LSU) into AR transactions and collects the R beats. Returns each beat to the client through a valid/ready port with a one-entry output buffer. Sits between core pipeline stages and the AXI arbiter/crossbar that feeds CLINT, SRAM and other responders.

Parameters:
- AXI_ID, 4'h0: constant driven on arid; expected on rid.
- TIMEOUT_CYCLES, 256: cycles without an R handshake before timeout. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- req_valid  in  1  client read request
- req_ready  out  1  master accepts request
- req_addr  in  32  start byte address
- req_len  in  8  beats minus 1 (arlen)
- req_size  in  3  bytes per beat, log2 (arsize); max 3'b010
- resp_valid  out  1  beat available to client
- resp_ready  in  1  client consumes beat
- resp_data  out  32  beat data
- resp_last  out  1  final beat of request
- resp_err  out  1  beat carries error
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- araddr  out  32  AXI AR address
- arid  out  4  AXI AR id (= AXI_ID)
- arlen  out  8  AXI AR burst length
- arsize  out  3  AXI AR size
- arburst  out  2  AXI AR burst type, fixed 2'b01 (INCR)
- rvalid  in  1  AXI R valid
- rready  out  1  AXI R ready
- rdata  in  32  AXI R data
- rresp  in  2  AXI R response
- rlast  in  1  AXI R last
- rid  in  4  AXI R id

Behaviour:
- Reset (rst=0, async): state IDLE. req_ready=1; arvalid=0; rready=0; resp_valid=0; resp_data=0; resp_last=0; resp_err=0; araddr=0; arlen=0; arsize=0. Beat counter = 0. arid=AXI_ID and arburst=2'b01 at all times.
- States: IDLE, ADDR, DATA.
- IDLE: req_ready=1. On req_valid & req_ready:
  - register addr/len/size onto araddr/arlen/arsize;
  - set arvalid=1 next cycle; req_ready=0; go to ADDR.
- ADDR: arvalid held high, AR fields stable until arvalid & arready. Then arvalid=0 next cycle, counter = 0, go to DATA. arready high before arvalid is legal; the transfer completes on the first cycle both are high.
- DATA:
  - rready = !resp_valid | resp_ready (one-entry buffer free or draining).
  - On rvalid & rready: resp_valid=1 next cycle; resp_data=rdata; resp_last=rlast; counter increments.
  - resp_err=1 on that beat if any of: rresp != 2'b00; rid != AXI_ID; rlast=1 while counter != arlen; rlast=0 while counter == arlen.
  - An accepted beat that is both last and error-free, or any beat with rlast=1, ends the transaction: go to IDLE, req_ready=1.
  - The final beat may still be held in the buffer. A new request may be accepted while it waits.
  - A beat with a length-mismatch error and rlast=0 at counter==arlen also ends the transaction; resp_last is forced to 1.
- Output buffer: resp_valid clears on resp_valid & resp_ready unless a new beat is loaded in the same cycle. Simultaneous drain+load leaves resp_valid=1 with the new beat. No beat is ever dropped or duplicated.
- Latency:
  - request accept to arvalid: 1 cycle;
  - R handshake to resp_valid: 1 cycle;
  - best case single beat: 3 cycles from req accept to resp_valid.
- Counter is 8 bits. arlen=8'hFF gives 256 beats with no wrap error.
- Reset mid-transaction aborts immediately; no AR or R state survives. Responder-side recovery is outside this block.

Optional Feature:
- Macro AXI_RD_TIMEOUT_EN.
- Defined: a 16-bit idle counter runs in ADDR and DATA. It resets on any AR or R handshake. On reaching TIMEOUT_CYCLES:
  - the master drops arvalid/rready;
  - it emits one beat with resp_valid=1, resp_err=1, resp_last=1, resp_data=32'hDEAD_BEEF;
  - it returns to IDLE.
- Undefined: no counter; the master waits indefinitely.

Test Plan:
1. Single read, addr 32'h0200_0000, len 0, size 2. Responder holds arready=1 and returns rdata 32'h0000_0042, rresp 0, rlast 1, rid 0. Expect: arvalid on cycle +1; resp_valid with data 32'h42, last=1, err=0 on cycle +3; req_ready=1 again.
2. AR backpressure: arready held low for 5 cycles. Expect arvalid=1 with araddr/arlen/arsize unchanged throughout; exactly one AR handshake.
3. Burst len 3 with beats 1,2,3,4 and resp_ready toggling 1,0,1,0. Expect four resp beats in order; resp_last only on beat 4; rready low whenever the buffer is full and resp_ready=0.
4. Error cases:
   - beat with rresp=2'b10 → resp_err=1;
   - rid=4'h5 → resp_err=1;
   - len 3 with rlast on beat 2 → err=1, last=1, back to IDLE.
5. rst pulled low during DATA after 2 of 4 beats. Expect all outputs at reset values asynchronously. After release, a fresh request runs cleanly.
6. With AXI_RD_TIMEOUT_EN and TIMEOUT_CYCLES=16, responder never asserts rvalid. Expect a single resp beat with err=1, last=1, data 32'hDEADBEEF, 16 cycles after the AR handshake.

Source files
------------

// File: rtl/ysyx_25020037_axi_rd_master.sv
// AXI4 read-channel initiator: one client request -> one AR burst, R beats returned
// through a one-entry output buffer. Optional R/AR watchdog under AXI_RD_TIMEOUT_EN.
module ysyx_25020037_axi_rd_master #(
  parameter logic [3:0] AXI_ID         = 4'h0,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        resp_err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  // The idle counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic        arvalid_q, arvalid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_last_q, resp_last_d;
  logic        resp_err_q, resp_err_d;

  logic        buf_free;
  logic        at_last;
  logic        beat_err;

  assign buf_free = !resp_valid_q || resp_ready;
  assign at_last  = (cnt_q == arlen_q);
  // A beat is erroneous if the responder flags it, it is for another id, or rlast
  // disagrees with our own beat count.
  assign beat_err = (rresp != 2'b00) || (rid != AXI_ID) || (rlast != at_last);

`ifdef AXI_RD_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] idle_q, idle_d;
  logic        to_hit;
  assign to_hit = (idle_q >= TO_LIMIT);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb infers a latch.
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arvalid_d    = arvalid_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_last_d  = resp_last_q;
    resp_err_d   = resp_err_q;
    req_ready    = (state_q == IDLE);
    rready       = 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
    idle_d       = (state_q == IDLE) ? 16'd0 : (to_hit ? idle_q : idle_q + 16'd1);
`endif

    if (resp_valid_q && resp_ready) resp_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          araddr_d  = req_addr;
          arlen_d   = req_len;
          arsize_d  = req_size;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          cnt_d     = 8'd0;
          state_d   = DATA;
`ifdef AXI_RD_TIMEOUT_EN
          idle_d    = 16'd0;
        end else if (to_hit) begin
          arvalid_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_data_d  = 32'hDEAD_BEEF;
          resp_last_d  = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
`endif
        end
      end
      DATA: begin
`ifdef AXI_RD_TIMEOUT_EN
        rready = buf_free && !to_hit;
        if (to_hit && buf_free) begin
          resp_valid_d = 1'b1;
          resp_data_d  = 32'hDEAD_BEEF;
          resp_last_d  = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = IDLE;
        end
`else
        rready = buf_free;
`endif
        if (rvalid && rready) begin
          resp_valid_d = 1'b1;
          resp_data_d  = rdata;
          resp_last_d  = rlast || at_last;
          resp_err_d   = beat_err;
          cnt_d        = cnt_q + 8'd1;
          if (rlast || at_last) state_d = IDLE;
`ifdef AXI_RD_TIMEOUT_EN
          idle_d       = 16'd0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arvalid_q    <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_last_q  <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef AXI_RD_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arvalid_q    <= arvalid_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_last_q  <= resp_last_d;
      resp_err_q   <= resp_err_d;
`ifdef AXI_RD_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign arvalid    = arvalid_q;
  assign araddr     = araddr_q;
  assign arlen      = arlen_q;
  assign arsize     = arsize_q;
  assign arid       = AXI_ID;
  assign arburst    = 2'b01;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_25020037_axi_rd_master.sv
// Directed bench for the AXI read master: latency, AR backpressure, buffered burst,
// error beats, async reset mid-burst, and (with AXI_RD_TIMEOUT_EN) the watchdog.
module tb_ysyx_25020037_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_last, resp_err;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int total = 0;
  int bad   = 0;
  int ar_hs = 0;

  ysyx_25020037_axi_rd_master #(.AXI_ID(4'h0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (arvalid && arready) ar_hs++;

  task automatic step();
    @(negedge clk);
  endtask

  // Accept a request and complete the AR handshake with arready=1; returns on the
  // first negedge in DATA.
  task automatic do_request(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_wait: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; req_addr = a; req_len = l; req_size = s; arready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    arready = 1'b0;
  endtask

  // Present one R beat, hold it until rready, then retire it; the beat is in the
  // output buffer on return.
  task automatic deliver_beat(input logic [31:0] d, input logic [1:0] rs,
                              input logic lst, input logic [3:0] id);
    int n = 0;
    rvalid = 1'b1; rdata = d; rresp = rs; rlast = lst; rid = id;
    #1;
    while (!rready && n < 20) begin step(); #1; n++; end
    if (!rready) begin
      total++; bad++;
      $display("FAIL rready_wait: rready=%b required 1", rready);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 4'h0;
  endtask

  task automatic test_reset();
    #3;
    total++; if ({req_ready, arvalid, rready, resp_valid, resp_last, resp_err} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b required 100000",
                      {req_ready, arvalid, rready, resp_valid, resp_last, resp_err});
    end
    total++; if ({resp_data, araddr, arlen, arsize} !== 75'd0) begin
      bad++; $display("FAIL reset_data: resp_data=%h araddr=%h arlen=%h arsize=%h required 0",
                      resp_data, araddr, arlen, arsize);
    end
    total++; if ({arid, arburst} !== 6'b0000_01) begin
      bad++; $display("FAIL reset_arconst: arid=%h arburst=%b required 0/01", arid, arburst);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL single_idle_ready: got %b required 1", req_ready);
    end
    req_valid = 1'b1; req_addr = 32'h0200_0000; req_len = 8'd0; req_size = 3'd2; arready = 1'b1;
    step();
    req_valid = 1'b0;
    total++; if ({arvalid, req_ready} !== 2'b10 || araddr !== 32'h0200_0000 || arlen !== 8'd0 || arsize !== 3'd2) begin
      bad++; $display("FAIL single_ar: arvalid=%b req_ready=%b araddr=%h arlen=%h arsize=%h required 1 0 02000000 00 2",
                      arvalid, req_ready, araddr, arlen, arsize);
    end
    step();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0000_0042; rresp = 2'b00; rlast = 1'b1; rid = 4'h0;
    #1;
    total++; if ({arvalid, rready, resp_valid} !== 3'b010) begin
      bad++; $display("FAIL single_data_phase: arvalid/rready/resp_valid=%b required 010",
                      {arvalid, rready, resp_valid});
    end
    step();
    rvalid = 1'b0; rlast = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'h42 || resp_last !== 1'b1 || resp_err !== 1'b0) begin
      bad++; $display("FAIL single_resp: valid=%b data=%h last=%b err=%b required 1 00000042 1 0",
                      resp_valid, resp_data, resp_last, resp_err);
    end
    total++; if (req_ready !== 1'b1) begin
      bad++; $display("FAIL single_req_ready_again: got %b required 1", req_ready);
    end
    step();
    total++; if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain: resp_valid=%b required 0", resp_valid);
    end
  endtask

  task automatic test_ar_backpressure();
    int hs0 = ar_hs;
    req_valid = 1'b1; req_addr = 32'h8000_0010; req_len = 8'd1; req_size = 3'd1; arready = 1'b0;
    step();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_len = 8'hAA; req_size = 3'd7;
    for (int i = 0; i < 5; i++) begin
      total++; if (arvalid !== 1'b1 || araddr !== 32'h8000_0010 || arlen !== 8'd1 || arsize !== 3'd1) begin
        bad++; $display("FAIL ar_hold[%0d]: arvalid=%b araddr=%h arlen=%h arsize=%h required 1 80000010 01 1",
                        i, arvalid, araddr, arlen, arsize);
      end
      step();
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    total++; if (arvalid !== 1'b0 || ar_hs - hs0 !== 1) begin
      bad++; $display("FAIL ar_once: arvalid=%b handshakes=%0d required 0 1", arvalid, ar_hs - hs0);
    end
    deliver_beat(32'h0000_00A1, 2'b00, 1'b0, 4'h0);
    total++; if (resp_data !== 32'hA1 || resp_last !== 1'b0 || resp_err !== 1'b0) begin
      bad++; $display("FAIL bp_beat0: data=%h last=%b err=%b required a1 0 0", resp_data, resp_last, resp_err);
    end
    deliver_beat(32'h0000_00A2, 2'b00, 1'b1, 4'h0);
    total++; if (resp_data !== 32'hA2 || resp_last !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_beat1: data=%h last=%b err=%b req_ready=%b required a2 1 0 1",
                      resp_data, resp_last, resp_err, req_ready);
    end
    step();
  endtask

  // Four-beat burst with resp_ready alternating 1,0,...; a bench-side model of the
  // one-entry buffer predicts resp_valid/resp_data and rready every cycle.
  task automatic test_burst_buffer();
    int idx = 0, drained = 0, c = 0;
    logic mv = 1'b0, exp_rr, drain, load;
    logic [31:0] md = '0;
    do_request(32'h0000_1000, 8'd3, 3'd2);
    while (drained < 4 && c < 40) begin
      total++; if (resp_valid !== mv || (mv && (resp_data !== md || resp_last !== (md == 32'd4) || resp_err !== 1'b0))) begin
        bad++; $display("FAIL burst_out[c%0d]: valid=%b data=%h last=%b err=%b required %b %h %b 0",
                        c, resp_valid, resp_data, resp_last, resp_err, mv, md, (md == 32'd4));
      end
      resp_ready = (c % 2 == 0);
      rvalid = (idx < 4); rdata = 32'(idx + 1); rlast = (idx == 3); rresp = 2'b00; rid = 4'h0;
      #1;
      exp_rr = (idx < 4) && (!mv || resp_ready);
      total++; if (rready !== exp_rr) begin
        bad++; $display("FAIL burst_rready[c%0d]: got %b required %b", c, rready, exp_rr);
      end
      if (idx == 4 && mv) begin
        total++; if (req_ready !== 1'b1) begin
          bad++; $display("FAIL burst_accept_while_held: req_ready=%b required 1", req_ready);
        end
      end
      drain = mv && resp_ready;
      load  = rvalid && exp_rr;
      if (drain) drained++;
      if (load) begin mv = 1'b1; md = 32'(idx + 1); idx++; end
      else if (drain) mv = 1'b0;
      step();
      c++;
    end
    rvalid = 1'b0; rlast = 1'b0; resp_ready = 1'b1;
    total++; if (drained !== 4 || resp_valid !== 1'b0) begin
      bad++; $display("FAIL burst_done: drained=%0d resp_valid=%b required 4 0", drained, resp_valid);
    end
  endtask

  task automatic test_errors();
    do_request(32'h0000_2000, 8'd0, 3'd2);
    deliver_beat(32'h0000_0011, 2'b10, 1'b1, 4'h0);
    total++; if (resp_err !== 1'b1 || resp_last !== 1'b1 || resp_data !== 32'h11) begin
      bad++; $display("FAIL err_rresp: err=%b last=%b data=%h required 1 1 11", resp_err, resp_last, resp_data);
    end
    do_request(32'h0000_2004, 8'd0, 3'd2);
    deliver_beat(32'h0000_0022, 2'b00, 1'b1, 4'h5);
    total++; if (resp_err !== 1'b1 || resp_last !== 1'b1) begin
      bad++; $display("FAIL err_rid: err=%b last=%b required 1 1", resp_err, resp_last);
    end
    do_request(32'h0000_2008, 8'd3, 3'd2);
    deliver_beat(32'h0000_0033, 2'b00, 1'b0, 4'h0);
    total++; if (resp_err !== 1'b0 || resp_last !== 1'b0) begin
      bad++; $display("FAIL err_early_beat0: err=%b last=%b required 0 0", resp_err, resp_last);
    end
    deliver_beat(32'h0000_0044, 2'b00, 1'b1, 4'h0);
    total++; if (resp_err !== 1'b1 || resp_last !== 1'b1 || req_ready !== 1'b1 || rready !== 1'b0) begin
      bad++; $display("FAIL err_early_last: err=%b last=%b req_ready=%b rready=%b required 1 1 1 0",
                      resp_err, resp_last, req_ready, rready);
    end
    do_request(32'h0000_200C, 8'd1, 3'd2);
    deliver_beat(32'h0000_0055, 2'b00, 1'b0, 4'h0);
    deliver_beat(32'h0000_0066, 2'b00, 1'b0, 4'h0);
    total++; if (resp_err !== 1'b1 || resp_last !== 1'b1 || resp_data !== 32'h66 || req_ready !== 1'b1) begin
      bad++; $display("FAIL err_missing_last: err=%b last=%b data=%h req_ready=%b required 1 1 66 1",
                      resp_err, resp_last, resp_data, req_ready);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_request(32'h0000_3000, 8'd3, 3'd2);
    deliver_beat(32'h0000_0077, 2'b00, 1'b0, 4'h0);
    deliver_beat(32'h0000_0088, 2'b00, 1'b0, 4'h0);
    #2 rst = 1'b0;
    #1;
    total++; if ({req_ready, arvalid, rready, resp_valid, resp_last, resp_err} !== 6'b100000 ||
                 {resp_data, araddr, arlen, arsize} !== 75'd0) begin
      bad++; $display("FAIL reset_mid: ctrl=%b data=%h araddr=%h arlen=%h arsize=%h required 100000 0 0 0 0",
                      {req_ready, arvalid, rready, resp_valid, resp_last, resp_err},
                      resp_data, araddr, arlen, arsize);
    end
    step();
    rst = 1'b1;
    step();
    do_request(32'h0000_4000, 8'd0, 3'd2);
    deliver_beat(32'h0000_0099, 2'b00, 1'b1, 4'h0);
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'h99 || resp_last !== 1'b1 || resp_err !== 1'b0) begin
      bad++; $display("FAIL reset_recover: valid=%b data=%h last=%b err=%b required 1 99 1 0",
                      resp_valid, resp_data, resp_last, resp_err);
    end
    step();
  endtask

`ifdef AXI_RD_TIMEOUT_EN
  task automatic test_timeout();
    do_request(32'h0000_5000, 8'd0, 3'd2);
    repeat (15) step();
    total++; if (resp_valid !== 1'b0 || rready !== 1'b0) begin
      bad++; $display("FAIL timeout_pre: resp_valid=%b rready=%b required 0 0", resp_valid, rready);
    end
    step();
    total++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF || resp_err !== 1'b1 ||
                 resp_last !== 1'b1 || req_ready !== 1'b1) begin
      bad++; $display("FAIL timeout_beat: valid=%b data=%h err=%b last=%b req_ready=%b required 1 deadbeef 1 1 1",
                      resp_valid, resp_data, resp_err, resp_last, req_ready);
    end
    step();
    total++; if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL timeout_single: resp_valid=%b required 0", resp_valid);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    resp_ready = 1'b1; arready = 1'b0;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 4'h0;
    test_reset();
    test_single();
    test_ar_backpressure();
    test_burst_buffer();
    test_errors();
    test_reset_mid_burst();
`ifdef AXI_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
